// File: rtl/m_lsu_master_if.sv
// m_lsu_master_if
//   Requester/responder bundle between the M-stage load/store master and an
//   external data-memory responder. One outstanding request at a time.
//
//   bus_req_valid  master->slave  request valid
//   bus_req_ready  slave->master  responder accepts the request
//   bus_addr       master->slave  word-aligned byte address
//   bus_we         master->slave  1 = write
//   bus_be         master->slave  byte enables, bit i = lane i
//   bus_wdata      master->slave  lane-replicated write data
//   bus_resp_valid slave->master  response for the outstanding request
//   bus_rdata      slave->master  read data, qualified by bus_resp_valid
interface m_lsu_master_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/m_lsu_master.sv
// m_lsu_master
//   M-stage load/store initiator. Checks alignment/type of the pipeline's
//   access, issues one valid/ready request on the data bus, waits for the
//   response (or a timeout) and returns extended load data.
//
//   clk            system clock, rising edge
//   reset          asynchronous, active-low (0 = reset)
//   M_Req          pipeline access request, held until M_Done or exception
//   M_MemWrite     1 = store, 0 = load
//   M_MemDataType  000 word, 001 half, 010 byte, 011 uhalf, 100 ubyte
//   A              byte address
//   M_MemData      right-justified store data
//   M_Stall        freeze upstream stages
//   M_Done         one-cycle completion pulse
//   M_RD           extended load data, held until the next completion
//   M_AdEL/M_AdES  one-cycle load/store address-or-type exception
//   M_BusErr       one-cycle timeout flag, coincident with M_Done
//   bus            requester side of m_lsu_master_if
module m_lsu_master #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 M_Req,
  input  logic                 M_MemWrite,
  input  logic [2:0]           M_MemDataType,
  input  logic [31:0]          A,
  input  logic [31:0]          M_MemData,
  output logic                 M_Stall,
  output logic                 M_Done,
  output logic [31:0]          M_RD,
  output logic                 M_AdEL,
  output logic                 M_AdES,
  output logic                 M_BusErr,
  m_lsu_master_if.master       bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, wdata_q, rd_q;
  logic               we_q, err_q, req_valid;
  logic [3:0]         be_q;
  logic [2:0]         type_q;
  logic [1:0]         off_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               type_ok, align_ok, legal, accept, timeout;
  logic [3:0]         be_in;
  logic [31:0]        wdata_in;

  // Pick the lane of the response that the captured access targets and
  // extend it according to the captured type.
  function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = d >> {off, 3'b000};
    half = off[1] ? d[31:16] : d[15:0];
    case (t)
      3'b001:  extract = {{16{half[15]}}, half};
      3'b010:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b011:  extract = {16'h0000, half};
      3'b100:  extract = {24'h000000, sh[7:0]};
      default: extract = d;
    endcase
  endfunction

  // Decode type/alignment legality and the bus lane pattern from live inputs.
  // Unsigned types cannot be stored; codes 101-111 are illegal everywhere.
  always_comb begin
    type_ok  = 1'b0;
    align_ok = 1'b0;
    be_in    = 4'b0000;
    wdata_in = 32'h0;
    case (M_MemDataType)
      3'b000: begin
        type_ok  = 1'b1;
        align_ok = (A[1:0] == 2'b00);
        be_in    = 4'b1111;
        wdata_in = M_MemData;
      end
      3'b001, 3'b011: begin
        type_ok  = (M_MemDataType == 3'b001) | ~M_MemWrite;
        align_ok = ~A[0];
        be_in    = A[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{M_MemData[15:0]}};
      end
      3'b010, 3'b100: begin
        type_ok  = (M_MemDataType == 3'b010) | ~M_MemWrite;
        align_ok = 1'b1;
        be_in    = 4'b0001 << A[1:0];
        wdata_in = {4{M_MemData[7:0]}};
      end
      default: ;
    endcase
    if (!M_MemWrite) wdata_in = 32'h0;
  end

  assign legal   = type_ok & align_ok;
  assign accept  = (state_q == S_IDLE) & M_Req & legal;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and outputs. The combinational outputs that depend on live
  // pipeline inputs are gated by reset so everything reads 0 while held.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    M_Done    = 1'b0;
    M_BusErr  = 1'b0;
    M_AdEL    = 1'b0;
    M_AdES    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REQ;
        if (M_Req && !legal) begin
          M_AdEL = reset & ~M_MemWrite;
          M_AdES = reset & M_MemWrite;
        end
      end
      S_REQ: begin
        req_valid = 1'b1;
        if (bus.bus_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.bus_resp_valid || timeout) state_d = S_DONE;
      end
      S_DONE: begin
        M_Done   = 1'b1;
        M_BusErr = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    M_Stall = reset & M_Req & legal & (state_q != S_DONE);
  end

  // Captured request fields, timeout counter, error flag and load result.
  // A response on the last permitted WAIT cycle wins over the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= {A[31:2], 2'b00};
            we_q    <= M_MemWrite;
            be_q    <= be_in;
            wdata_q <= wdata_in;
            type_q  <= M_MemDataType;
            off_q   <= A[1:0];
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_REQ: begin
          if (bus.bus_req_ready) cnt_q <= '0;
        end
        S_WAIT: begin
          if (bus.bus_resp_valid) begin
            rd_q <= extract(type_q, off_q, bus.bus_rdata);
          end else if (timeout) begin
            err_q <= 1'b1;
            rd_q  <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_req_valid = req_valid;
  assign bus.bus_addr      = addr_q;
  assign bus.bus_we        = we_q;
  assign bus.bus_be        = be_q;
  assign bus.bus_wdata     = wdata_q;
  assign M_RD              = rd_q;

endmodule

// File: tb/tb_m_lsu_master.sv
// tb_m_lsu_master
//   Self-checking bench for m_lsu_master: a table of hand-derived vectors,
//   reset / exception corner sequences, then random accesses whose expected
//   results come from an arithmetic reference model of the access rules.
module tb_m_lsu_master;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mReq, mMemWrite;
  logic [2:0]  mType;
  logic [31:0] addrIn, memData;
  logic        mStall, mDone, mAdEL, mAdES, mBusErr;
  logic [31:0] mRd;
  int          checks = 0;
  int          errors = 0;

  m_lsu_master_if busIf();

  m_lsu_master #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .M_Req(mReq), .M_MemWrite(mMemWrite),
    .M_MemDataType(mType), .A(addrIn), .M_MemData(memData),
    .M_Stall(mStall), .M_Done(mDone), .M_RD(mRd), .M_AdEL(mAdEL),
    .M_AdES(mAdES), .M_BusErr(mBusErr), .bus(busIf.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  dtype;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          readyDelay;
    int          respDelay;
    logic        expLegal;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRd;
    logic        expErr;
  } vec_t;

  vec_t vecTable[$];

  task automatic checkOutput(input string what, input int id, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s (vec %0d): got %h, expected %h", what, id, got, want);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] t, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rdata,
                              input int rdy, input int resp, input logic legal,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] rd, input logic err);
    vec_t v;
    v.we = we; v.dtype = t; v.addr = addr; v.data = data; v.rdata = rdata;
    v.readyDelay = rdy; v.respDelay = resp; v.expLegal = legal; v.expBe = be;
    v.expWdata = wdata; v.expRd = rd; v.expErr = err;
    return v;
  endfunction

  // Reference model: access size in bytes, signedness, legality as
  // "address divisible by size", lanes and replication by arithmetic.
  function automatic vec_t modelVec(input logic we, input logic [2:0] t, input logic [31:0] addr,
                                    input logic [31:0] data, input logic [31:0] rdata,
                                    input int rdy, input int resp);
    vec_t v;
    int size, off;
    bit sgn, ok;
    logic [31:0] mask, lane, rep;
    size = 1; sgn = 0; ok = 0;
    case (t)
      3'd0: begin size = 4; sgn = 1; ok = 1; end
      3'd1: begin size = 2; sgn = 1; ok = 1; end
      3'd2: begin size = 1; sgn = 1; ok = 1; end
      3'd3: begin size = 2; sgn = 0; ok = !we; end
      3'd4: begin size = 1; sgn = 0; ok = !we; end
      default: ok = 0;
    endcase
    off  = int'(addr % 4);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    rep  = (size == 4) ? 32'd1 : (size == 2) ? 32'h0001_0001 : 32'h0101_0101;
    lane = (rdata >> (8 * off)) & mask;
    if (sgn && size < 4 && lane[8 * size - 1]) lane = lane | ~mask;
    v = mk(we, t, addr, data, rdata, rdy, resp, ok && (off % size == 0),
           4'(((1 << size) - 1) << off), we ? (data & mask) * rep : 32'h0,
           (resp < 0) ? 32'h0 : lane, resp < 0);
    return v;
  endfunction

  // Runs one access from the pipeline side while acting as the responder.
  task automatic applyStimulus(input vec_t v, input int id);
    logic [31:0] expAddr;
    int latency;
    bit done;
    expAddr = v.addr - (v.addr % 4);
    @(posedge clk); #1;
    mReq = 1'b1; mMemWrite = v.we; mType = v.dtype; addrIn = v.addr; memData = v.data;
    busIf.bus_req_ready = 1'b0; busIf.bus_resp_valid = 1'b0;
    @(negedge clk);
    if (!v.expLegal) begin
      checkOutput("adel", id, mAdEL, !v.we);
      checkOutput("ades", id, mAdES, v.we);
      checkOutput("exc_stall", id, mStall, 1'b0);
      checkOutput("exc_valid", id, busIf.bus_req_valid, 1'b0);
      @(posedge clk); #1;
      mReq = 1'b0;
      @(negedge clk);
      checkOutput("exc_after_valid", id, busIf.bus_req_valid, 1'b0);
      checkOutput("exc_after_adel", id, mAdEL | mAdES, 1'b0);
      checkOutput("exc_after_done", id, mDone, 1'b0);
      return;
    end
    checkOutput("accept_stall", id, mStall, 1'b1);
    checkOutput("accept_exc", id, mAdEL | mAdES, 1'b0);
    checkOutput("accept_valid", id, busIf.bus_req_valid, 1'b0);
    @(posedge clk); #1;
    for (int n = 0; n <= v.readyDelay; n++) begin
      busIf.bus_req_ready = (n == v.readyDelay);
      @(negedge clk);
      checkOutput("req_valid", id, busIf.bus_req_valid, 1'b1);
      checkOutput("req_addr", id, busIf.bus_addr, expAddr);
      checkOutput("req_we", id, busIf.bus_we, v.we);
      checkOutput("req_be", id, busIf.bus_be, v.expBe);
      checkOutput("req_wdata", id, busIf.bus_wdata, v.expWdata);
      checkOutput("req_stall", id, mStall, 1'b1);
      @(posedge clk); #1;
    end
    busIf.bus_req_ready = 1'b0;
    done = 0;
    latency = -1;
    for (int m = 0; m < TIMEOUT + 4 && !done; m++) begin
      busIf.bus_resp_valid = (m == v.respDelay);
      busIf.bus_rdata = (m == v.respDelay) ? v.rdata : $urandom;
      @(negedge clk);
      if (mDone) begin
        done = 1;
        latency = m;
      end else begin
        checkOutput("wait_valid", id, busIf.bus_req_valid, 1'b0);
        checkOutput("wait_stall", id, mStall, 1'b1);
        @(posedge clk); #1;
      end
    end
    checkOutput("done_seen", id, done, 1'b1);
    if (done) begin
      checkOutput("latency", id, latency, (v.respDelay >= 0) ? v.respDelay + 1 : TIMEOUT);
      checkOutput("buserr", id, mBusErr, v.expErr);
      checkOutput("done_stall", id, mStall, 1'b0);
      if (!v.we) checkOutput("rd", id, mRd, v.expRd);
    end
    @(posedge clk); #1;
    mReq = 1'b0; busIf.bus_resp_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", id, mDone | mBusErr, 1'b0);
    if (done && !v.we) checkOutput("rd_hold", id, mRd, v.expRd);
  endtask

  initial begin
    vec_t v;
    int resp;
    mReq = 0; mMemWrite = 0; mType = 0; addrIn = 0; memData = 0;
    busIf.bus_req_ready = 0; busIf.bus_resp_valid = 0; busIf.bus_rdata = 0;

    // we, type, addr, data, rdata, rdy, resp, legal, be, wdata, rd, err
    vecTable.push_back(mk(0, 3'd0, 32'h10, 0, 32'hDEADBEEF, 0, 0, 1, 4'hF, 0, 32'hDEADBEEF, 0));
    vecTable.push_back(mk(1, 3'd2, 32'h23, 32'hA5, 0, 0, 0, 1, 4'h8, 32'hA5A5A5A5, 0, 0));
    vecTable.push_back(mk(0, 3'd1, 32'h06, 0, 32'h80011234, 0, 1, 1, 4'hC, 0, 32'hFFFF8001, 0));
    vecTable.push_back(mk(0, 3'd3, 32'h06, 0, 32'h80011234, 1, 0, 1, 4'hC, 0, 32'h00008001, 0));
    vecTable.push_back(mk(0, 3'd2, 32'h05, 0, 32'h00009000, 0, 2, 1, 4'h2, 0, 32'hFFFFFF90, 0));
    vecTable.push_back(mk(0, 3'd0, 32'h02, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecTable.push_back(mk(1, 3'd3, 32'h04, 32'h1234, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecTable.push_back(mk(1, 3'd0, 32'h100, 32'h12345678, 0, 5, 0, 1, 4'hF, 32'h12345678, 0, 0));
    vecTable.push_back(mk(0, 3'd0, 32'h40, 0, 32'h11111111, 0, -1, 1, 4'hF, 0, 0, 1));
    vecTable.push_back(mk(0, 3'd4, 32'h07, 0, 32'h80FF0000, 0, 0, 1, 4'h8, 0, 32'h00000080, 0));
    vecTable.push_back(mk(1, 3'd1, 32'h02, 32'hFFFFBEEF, 0, 2, 3, 1, 4'hC, 32'hBEEFBEEF, 0, 0));
    vecTable.push_back(mk(0, 3'd5, 32'h00, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecTable.push_back(mk(1, 3'd4, 32'h01, 32'h77, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecTable.push_back(mk(0, 3'd1, 32'h01, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    vecTable.push_back(mk(0, 3'd2, 32'h03, 0, 32'h7F000000, 0, TIMEOUT - 1, 1, 4'h8, 0, 32'h0000007F, 0));
    vecTable.push_back(mk(0, 3'd2, 32'hFFFFFFFE, 0, 32'h00AB0000, 3, 1, 1, 4'h4, 0, 32'hFFFFFFAB, 0));

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", -1, busIf.bus_req_valid, 1'b0);
    checkOutput("rst_addr", -1, busIf.bus_addr, 32'h0);
    checkOutput("rst_be_we", -1, {busIf.bus_be, busIf.bus_we}, 5'h0);
    checkOutput("rst_wdata", -1, busIf.bus_wdata, 32'h0);
    checkOutput("rst_rd", -1, mRd, 32'h0);
    checkOutput("rst_flags", -1, {mStall, mDone, mAdEL, mAdES, mBusErr}, 5'h0);
    reset = 1'b1;

    for (int i = 0; i < vecTable.size(); i++) applyStimulus(vecTable[i], i);

    // Illegal request held high: the exception repeats every cycle.
    @(posedge clk); #1;
    mReq = 1; mMemWrite = 0; mType = 3'd0; addrIn = 32'h2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("repulse_adel", 200 + k, mAdEL, 1'b1);
      checkOutput("repulse_valid", 200 + k, busIf.bus_req_valid | mStall, 1'b0);
      @(posedge clk); #1;
    end
    mReq = 0;

    // Reset during REQ drops the request immediately.
    @(posedge clk); #1;
    mReq = 1; mMemWrite = 1; mType = 3'd0; addrIn = 32'h80; memData = 32'hCAFEF00D;
    busIf.bus_req_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstreq_valid_before", 300, busIf.bus_req_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rstreq_valid", 300, busIf.bus_req_valid, 1'b0);
    checkOutput("rstreq_wdata", 300, busIf.bus_wdata, 32'h0);
    checkOutput("rstreq_stall", 300, mStall, 1'b0);
    @(negedge clk);
    reset = 1'b1; mReq = 0;

    // Reset mid-WAIT, then a stray response after release is ignored.
    applyStimulus(vecTable[0], 301);
    @(posedge clk); #1;
    mReq = 1; mMemWrite = 0; mType = 3'd0; addrIn = 32'h44;
    @(posedge clk); #1;
    busIf.bus_req_ready = 1;
    @(posedge clk); #1;
    busIf.bus_req_ready = 0;
    @(negedge clk);
    checkOutput("rstwait_stall_before", 302, mStall, 1'b1);
    checkOutput("rstwait_rd_held", 302, mRd, 32'hDEADBEEF);
    #2 reset = 1'b0;
    #1;
    checkOutput("rstwait_rd", 302, mRd, 32'h0);
    checkOutput("rstwait_addr", 302, busIf.bus_addr, 32'h0);
    checkOutput("rstwait_flags", 302, {mStall, mDone, busIf.bus_req_valid}, 3'h0);
    @(negedge clk);
    reset = 1'b1; mReq = 0;
    @(posedge clk); #1;
    busIf.bus_resp_valid = 1; busIf.bus_rdata = 32'h12345678;
    @(negedge clk);
    checkOutput("late_resp_done", 303, mDone, 1'b0);
    @(posedge clk); #1;
    busIf.bus_resp_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("late_resp_quiet", 304 + k, {mDone, busIf.bus_req_valid}, 2'b00);
      checkOutput("late_resp_rd", 304 + k, mRd, 32'h0);
    end

    // Random accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      resp = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
      v = modelVec(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 3)), resp);
      applyStimulus(v, 1000 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/m_lsu_master.md
Name: m_lsu_master

Overview:
- M-stage load/store initiator that owns the requester side of the data-memory interface.
- Takes the pipeline's access request (address, store data, write flag, data type) and checks alignment and type.
- Drives a valid/ready request plus response channel to an external memory responder: word-aligned address, byte enables, lane-replicated write data.
- Stalls the pipeline until the response arrives, then returns sign- or zero-extended load data.

Parameters:
- TIMEOUT, 64: max cycles spent in WAIT before a bus error is declared (≥2).
- CNT_W, 7: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- M_Req  input  1  pipeline requests a memory access this cycle; held until M_Done or exception.
- M_MemWrite  input  1  1 = store, 0 = load.
- M_MemDataType  input  3  000 word, 001 half, 010 byte, 011 uhalf, 100 ubyte; 101–111 illegal.
- A  input  32  byte address.
- M_MemData  input  32  store data, right-justified.
- M_Stall  output  1  freeze upstream stages.
- M_Done  output  1  one-cycle pulse: access complete.
- M_RD  output  32  extended load data; valid when M_Done & ~M_MemWrite.
- M_AdEL  output  1  one-cycle pulse: load address/type exception.
- M_AdES  output  1  one-cycle pulse: store address/type exception.
- M_BusErr  output  1  one-cycle pulse, coincident with M_Done, on timeout.
- bus_req_valid  output  1  request valid.
- bus_req_ready  input  1  responder accepts request.
- bus_addr  output  32  {A[31:2],2'b00}.
- bus_we  output  1  write request.
- bus_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- bus_wdata  output  32  lane-replicated store data.
- bus_resp_valid  input  1  response/ack for the outstanding request.
- bus_rdata  input  32  read data; sampled when bus_resp_valid is high in WAIT.

Behaviour:
- Reset, asynchronous, reset=0: state=IDLE, counter=0, all outputs 0, captured request fields cleared. Reset during REQ or WAIT abandons the access: bus_req_valid drops immediately. A late bus_resp_valid seen in IDLE is ignored.
- Legality check, done in IDLE:
  - Word needs A[1:0]=00; half/uhalf need A[0]=0; byte/ubyte always legal.
  - Stores allow only types 000, 001, 010. Types 101–111 are illegal for either direction.
  - Illegal access: one-cycle M_AdEL (load) or M_AdES (store), state stays IDLE, no bus activity, M_Stall=0 that cycle.
  - The pipeline is expected to drop M_Req after an exception. If M_Req stays high, the exception re-pulses every cycle.
- Byte enables and write data:
  - Word: be=1111, wdata=M_MemData.
  - Half: be=0011<<(2*A[1]), wdata={2{M_MemData[15:0]}}.
  - Byte: be=0001<<A[1:0], wdata={4{M_MemData[7:0]}}.
  - Loads drive the same be pattern with wdata=0.
- State machine, outputs registered from captured fields:
  - IDLE: on a legal M_Req, capture addr, we, be, wdata, type and byte offset, then go to REQ.
  - REQ: bus_req_valid=1. If bus_req_ready, go to WAIT and clear the counter; otherwise hold. Fields stay stable while valid and not ready.
  - WAIT: bus_req_valid=0. If bus_resp_valid, latch the extracted, extended load data into M_RD and go to DONE. Otherwise increment the counter; when it reaches TIMEOUT-1, set the error flag and go to DONE with M_RD=0.
  - DONE: M_Done=1, M_BusErr=error flag, then go to IDLE. M_RD holds until the next DONE.
- Load extraction:
  - Word: rdata.
  - Half: lane rdata[16*A[1]+15 -: 16], sign-extended.
  - Uhalf: same lane, zero-extended.
  - Byte: rdata[8*A[1:0]+7 -: 8], sign-extended.
  - Ubyte: same lane, zero-extended.
- M_Stall is combinational: M_Req & legal & (state != DONE). It is high in the IDLE accept cycle, REQ and WAIT, and low in DONE so the pipeline advances exactly once.
- Minimum latency with ready=1 and resp the cycle after acceptance:
  - Accept in IDLE (cycle 0).
  - REQ (cycle 1).
  - WAIT with resp (cycle 2).
  - DONE (cycle 3).
- Only one outstanding request; a new access is not accepted in DONE.

Test Plan:
- Load word, A=0x0000_0010, ready=1, resp next cycle with rdata=0xDEAD_BEEF -> bus_addr=0x10, be=1111, we=0; M_Done in cycle 3 with M_RD=0xDEADBEEF; M_Stall high in cycles 0–2.
- Store byte, A=0x23, M_MemData=0x0000_00A5 -> be=1000, wdata=0xA5A5A5A5, we=1; M_Done after resp; no M_AdES.
- Load half, A=0x06, rdata=0x8001_1234 -> M_RD=0xFFFF8001. Same access as uhalf -> 0x00008001. Byte load at A=0x05 with rdata=0x0000_9000 -> 0xFFFFFF90.
- Misaligned load word at A=0x02 -> M_AdEL pulse, bus_req_valid stays 0. Store uhalf at A=0x04 -> M_AdES.
- ready held low 5 cycles, then high -> bus_req_valid and all fields stable for 5 cycles, transfer on the 6th. No resp for TIMEOUT cycles -> M_Done and M_BusErr together, M_RD=0.
- reset=0 asserted mid-WAIT -> all outputs 0 immediately. A resp_valid pulse after reset release -> ignored, no M_Done.
